load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Core-side initiator for the word-only data bus served by memory_system (data_addr/data_wr/data_we/data_rd).
- Accepts byte, halfword and word load/store requests from the execute stage.
- Drives word-aligned bus cycles and sign- or zero-extends load data.
- Implements sub-word stores as read-modify-write, because the bus has no byte enables and reads have 1-cycle registered latency.

Parameters:
- ALIGN_CHECK, 1: 1 = misaligned half/word requests are rejected with resp_err_out. 0 = low address bits are ignored and the access is forced to natural alignment.

Ports:
- clk_in  input  1  clock
- rst_low_in  input  1  reset, asynchronous, active-low
- req_valid_in  input  1  core request valid
- req_ready_out  output  1  LSU can accept a request (high only in IDLE)
- req_we_in  input  1  1 = store, 0 = load
- req_size_in  input  2  lsu_size_t: 00 byte, 01 half, 10 word, 11 reserved
- req_unsigned_in  input  1  load zero-extend (1) / sign-extend (0)
- req_addr_in  input  32  byte address
- req_wdata_in  input  32  store data, right-justified
- resp_valid_out  output  1  one-cycle completion pulse
- resp_rdata_out  output  32  extended load data; 0 for stores and errors
- resp_err_out  output  1  misaligned or reserved size; qualified by resp_valid_out
- mem_addr_out  output  32  to data_addr_in, always {addr[31:2],2'b00}
- mem_wr_out  output  32  to data_wr_in
- mem_we_out  output  1  to data_we_in
- mem_rd_in  input  32  from data_rd_out, valid the cycle after the address is presented

Behaviour:
- Reset (asynchronous): state IDLE. All outputs and internal registers 0, except req_ready_out = 1 once out of reset.
- Handshake: request accepted at a rising edge with req_valid_in && req_ready_out. Address, size, unsigned flag and wdata are captured at that edge. Request inputs are ignored while not ready.
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- Paths, counted from accept edge k:
  - Load: IDLE → RD_ADDR (present addr; memory registers data at k+1) → RD_DATA (extract and extend mem_rd_in; register into resp_rdata at k+2) → RESP (resp_valid high one cycle) → IDLE. resp_valid_out is high in the cycle after edge k+2; next accept is possible at edge k+4.
  - Word store: IDLE → WR (mem_we_out=1, mem_wr_out=wdata; memory writes at k+1) → RESP → IDLE.
  - Byte/half store: IDLE → RD_ADDR → RD_DATA (merge new lane(s) into mem_rd_in, register merged word) → WR (write merged word) → RESP → IDLE.
  - Error: IDLE → RESP with resp_err_out=1, resp_rdata_out=0. mem_we_out is never asserted and no bus read is performed.
- Error conditions: size 11; half with addr[0]=1; word with addr[1:0]≠00. Alignment errors are reported only when ALIGN_CHECK=1; size 11 is always an error.
- mem_we_out is high only in WR, exactly one cycle per store.
- mem_addr_out holds the aligned address in every non-IDLE state and is 0 in IDLE.
- mem_wr_out is 0 outside WR.
- Lane select:
  - byte: addr[1:0] selects bits [8n+7:8n].
  - half: addr[1] selects [15:0] or [31:16].
  - Sign bit is the lane MSB.
- resp_rdata_out and resp_err_out hold their value only during RESP and are 0 otherwise.
- Reset asserted mid-operation (including during WR): immediate return to IDLE with mem_we_out=0. No response is issued for the aborted request.

Decomposition:
- Shared package lsu_pkg, alongside memory_system_pkg: typedef enum lsu_size_t, typedef enum lsu_state_t, constants LSU_SIZE_BYTE/HALF/WORD.
- One combinational sub-module lsu_data_align with two functions:
  - load extraction/extension: word, addr[1:0], size, unsigned → 32-bit result.
  - store merge: old word, new data, addr[1:0], size → merged word.
- FSM and registers stay in load_store_unit.

Test Plan:
- Connected to memory_system: word store 0x0000A5A5 to LED_BASE_ADDR → mem_we_out high exactly one cycle; led_out=0xA5A5 after that edge; resp_valid pulse, err=0.
- SSEG=0x11223344, byte store 0x3C to SSEG_BASE_ADDR+1 → RD_ADDR, RD_DATA, WR sequence observed; sseg_data_out=0x11223C44.
- SSEG=0x11228044, signed byte load from SSEG_BASE_ADDR+1 → resp_rdata 0xFFFFFF80 in the cycle after edge k+2. Same load unsigned → 0x00000080. Signed half at SSEG_BASE_ADDR+2 → 0x00001122.
- Half load at SSEG_BASE_ADDR+3 and word store at LED_BASE_ADDR+2 (ALIGN_CHECK=1) → resp_err=1, rdata=0, mem_we_out never high, led/sseg unchanged. Size 11 → err.
- req_valid held high for two back-to-back word loads from SWITCH_BASE_ADDR with sw_in=0xBEEF → req_ready low during the first; second accepted at k+4; both return 0x0000BEEF.
- rst_low_in asserted during WR of a byte store → mem_we_out drops asynchronously; target register unchanged; after release req_ready=1 and resp_valid=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Load/store unit shared types.
//   lsu_size_t  : request access size (byte, half, word, reserved)
//   lsu_state_t : LSU control states
//   lsu_req_err      : flags reserved size and, optionally, misalignment
//   lsu_force_align  : clears offset bits that natural alignment ignores
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_BYTE = 2'b00,
        LSU_SIZE_HALF = 2'b01,
        LSU_SIZE_WORD = 2'b10,
        LSU_SIZE_RSVD = 2'b11
    } lsu_size_t;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_RD_ADDR,
        LSU_RD_DATA,
        LSU_WR,
        LSU_RESP
    } lsu_state_t;

    function automatic logic lsu_req_err(lsu_size_t size, logic [1:0] off, logic align_check);
        logic err;
        err = 1'b0;
        case (size)
            LSU_SIZE_HALF: err = align_check & off[0];
            LSU_SIZE_WORD: err = align_check & (off != 2'b00);
            LSU_SIZE_RSVD: err = 1'b1;
            default:       err = 1'b0;
        endcase
        return err;
    endfunction

    function automatic logic [1:0] lsu_force_align(lsu_size_t size, logic [1:0] off);
        logic [1:0] r;
        case (size)
            LSU_SIZE_HALF: r = {off[1], 1'b0};
            LSU_SIZE_WORD: r = 2'b00;
            default:       r = off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and word data-bus signals of the load/store unit.
//   slave  : LSU side (accepts requests, drives the data bus)
//   master : environment side (core stage plus memory)
interface load_store_unit_if;
    import lsu_pkg::*;

    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_we_in;
    lsu_size_t   req_size_in;
    logic        req_unsigned_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic        resp_valid_out;
    logic [31:0] resp_rdata_out;
    logic        resp_err_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wr_out;
    logic        mem_we_out;
    logic [31:0] mem_rd_in;

    modport slave (
        input  req_valid_in, req_we_in, req_size_in, req_unsigned_in,
        input  req_addr_in, req_wdata_in, mem_rd_in,
        output req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
        output mem_addr_out, mem_wr_out, mem_we_out
    );

    modport master (
        output req_valid_in, req_we_in, req_size_in, req_unsigned_in,
        output req_addr_in, req_wdata_in, mem_rd_in,
        input  req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
        input  mem_addr_out, mem_wr_out, mem_we_out
    );

endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane handling for the load/store unit.
//   word_in     : word read from the bus
//   wdata_in    : right-justified store data
//   offset_in   : byte offset within the word
//   size_in     : access size
//   unsigned_in : zero-extend (1) / sign-extend (0) loads
//   load_out    : extracted and extended load value
//   merge_out   : word_in with the store lane(s) replaced
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [31:0] wdata_in,
    input  logic [1:0]  offset_in,
    input  lsu_size_t   size_in,
    input  logic        unsigned_in,
    output logic [31:0] load_out,
    output logic [31:0] merge_out
);

    function automatic logic [31:0] load_extract(logic [31:0] word, logic [1:0] off,
                                                 lsu_size_t size, logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            LSU_SIZE_BYTE: r = {{24{~uns & b[7]}}, b};
            LSU_SIZE_HALF: r = {{16{~uns & h[15]}}, h};
            LSU_SIZE_WORD: r = word;
            default:       r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(logic [31:0] old, logic [31:0] data,
                                                logic [1:0] off, lsu_size_t size);
        logic [31:0] m;
        m = old;
        case (size)
            LSU_SIZE_BYTE: begin
                case (off)
                    2'd0:    m[7:0]   = data[7:0];
                    2'd1:    m[15:8]  = data[7:0];
                    2'd2:    m[23:16] = data[7:0];
                    default: m[31:24] = data[7:0];
                endcase
            end
            LSU_SIZE_HALF: begin
                if (off[1]) m[31:16] = data[15:0];
                else        m[15:0]  = data[15:0];
            end
            LSU_SIZE_WORD: m = data;
            default:       m = old;
        endcase
        return m;
    endfunction

    always_comb begin
        load_out  = load_extract(word_in, offset_in, size_in, unsigned_in);
        merge_out = store_merge(word_in, wdata_in, offset_in, size_in);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: core-side initiator for a word-only data bus with
// 1-cycle registered read latency and no byte enables.
//   clk_in, rst_low_in : clock, asynchronous active-low reset
//   bus (slave)        : core request/response handshake and data bus
// Sub-word stores are read-modify-write; loads are sign/zero extended.
// ALIGN_CHECK = 1 rejects misaligned half/word accesses; 0 forces alignment.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_low_in,
    load_store_unit_if.slave  bus
);

    lsu_state_t  state, state_nx;
    logic [31:0] addr_q;
    lsu_size_t   size_q;
    logic        uns_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic [1:0]  req_off;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    lsu_data_align u_align (
        .word_in     (bus.mem_rd_in),
        .wdata_in    (wdata_q),
        .offset_in   (addr_q[1:0]),
        .size_in     (size_q),
        .unsigned_in (uns_q),
        .load_out    (load_val),
        .merge_out   (merge_val)
    );

    assign req_err = lsu_req_err(bus.req_size_in, bus.req_addr_in[1:0], ALIGN_CHECK);
    assign req_off = lsu_force_align(bus.req_size_in, bus.req_addr_in[1:0]);
    assign accept  = bus.req_valid_in && bus.req_ready_out;

    always_comb begin
        state_nx           = state;
        bus.req_ready_out  = (state == LSU_IDLE) && rst_low_in;
        bus.mem_addr_out   = (state != LSU_IDLE) ? {addr_q[31:2], 2'b00} : '0;
        bus.mem_we_out     = (state == LSU_WR);
        bus.mem_wr_out     = (state == LSU_WR) ? wdata_q : '0;
        bus.resp_valid_out = (state == LSU_RESP);
        bus.resp_rdata_out = (state == LSU_RESP) ? rdata_q : '0;
        bus.resp_err_out   = (state == LSU_RESP) && err_q;

        case (state)
            LSU_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nx = LSU_RESP;
                    else if (bus.req_we_in && bus.req_size_in == LSU_SIZE_WORD)
                        state_nx = LSU_WR;
                    else
                        state_nx = LSU_RD_ADDR;
                end
            end
            LSU_RD_ADDR: state_nx = LSU_RD_DATA;
            LSU_RD_DATA: state_nx = we_q ? LSU_WR : LSU_RESP;
            LSU_WR:      state_nx = LSU_RESP;
            LSU_RESP:    state_nx = LSU_IDLE;
            default:     state_nx = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            state   <= LSU_IDLE;
            addr_q  <= '0;
            size_q  <= LSU_SIZE_BYTE;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= {bus.req_addr_in[31:2], req_off};
                size_q  <= bus.req_size_in;
                uns_q   <= bus.req_unsigned_in;
                we_q    <= bus.req_we_in;
                wdata_q <= bus.req_wdata_in;
                rdata_q <= '0;
                err_q   <= req_err;
            end
            // Read data is valid only now; a store reuses wdata_q to hold the
            // merged word so WR drives it unchanged.
            if (state == LSU_RD_DATA) begin
                if (we_q) wdata_q <= merge_val;
                else      rdata_q <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory with 1-cycle registered reads on
// the bus, and a byte-array reference model of memory and responses.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk;
    logic rst_low;
    int   checks;
    int   errors;

    load_store_unit_if lsu_bus ();

    load_store_unit #(.ALIGN_CHECK(1'b1)) dut (
        .clk_in     (clk),
        .rst_low_in (rst_low),
        .bus        (lsu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-side memory: 16 words, preload port used only while in reset.
    logic [31:0] tb_mem [0:15];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) tb_mem[pl_idx] <= pl_data;
        else if (lsu_bus.mem_we_out) tb_mem[lsu_bus.mem_addr_out[5:2]] <= lsu_bus.mem_wr_out;
        lsu_bus.mem_rd_in <= tb_mem[lsu_bus.mem_addr_out[5:2]];
    end

    // Reference model: byte-addressed little-endian memory.
    logic [7:0] ref_bytes [0:63];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int unsigned widx);
        return {ref_bytes[4*widx+3], ref_bytes[4*widx+2], ref_bytes[4*widx+1], ref_bytes[4*widx]};
    endfunction

    task automatic do_req(input bit we, input int unsigned sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int unsigned nbytes, a, exp_lat, exp_we, we_cnt, resp_cnt, lat, waitn;
        longint      v;
        bit          exp_err;
        logic [31:0] exp_rdata, got_rdata, got_wr, got_waddr;
        logic        got_err;

        a       = addr[5:0];
        nbytes  = 1 << sz;
        exp_err = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
        exp_rdata = '0;
        if (exp_err) begin
            exp_lat = 1; exp_we = 0;
        end else if (we) begin
            for (int j = 0; j < int'(nbytes); j++) ref_bytes[a + j] = 8'(wd >> (8 * j));
            exp_lat = (sz == 2) ? 2 : 4; exp_we = 1;
        end else begin
            v = 0;
            for (int j = 0; j < int'(nbytes); j++) v = v + (longint'(ref_bytes[a + j]) << (8 * j));
            if (!uns && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
                v = v - (longint'(1) << (8 * nbytes));
            exp_rdata = 32'(v);
            exp_lat = 3; exp_we = 0;
        end

        @(negedge clk);
        waitn = 0;
        while (!lsu_bus.req_ready_out && waitn < 10) begin
            @(negedge clk);
            waitn++;
        end
        check("req_ready_before_accept", 32'(lsu_bus.req_ready_out), 32'd1);
        lsu_bus.req_valid_in    = 1'b1;
        lsu_bus.req_we_in       = we;
        lsu_bus.req_size_in     = lsu_size_t'(sz[1:0]);
        lsu_bus.req_unsigned_in = uns;
        lsu_bus.req_addr_in     = addr;
        lsu_bus.req_wdata_in    = wd;
        @(posedge clk);
        #1 lsu_bus.req_valid_in = 1'b0;

        we_cnt = 0; resp_cnt = 0; lat = 0;
        got_rdata = 'x; got_err = 1'bx; got_wr = 'x; got_waddr = 'x;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (lsu_bus.mem_we_out) begin
                we_cnt++;
                got_wr    = lsu_bus.mem_wr_out;
                got_waddr = lsu_bus.mem_addr_out;
            end
            if (lsu_bus.resp_valid_out) begin
                resp_cnt++;
                if (resp_cnt == 1) begin
                    lat       = i;
                    got_rdata = lsu_bus.resp_rdata_out;
                    got_err   = lsu_bus.resp_err_out;
                end
            end
        end
        check("resp_count", resp_cnt, 1);
        check("resp_latency", lat, exp_lat);
        check("resp_err", 32'(got_err), 32'(exp_err));
        check("resp_rdata", got_rdata, exp_rdata);
        check("mem_we_cycles", we_cnt, exp_we);
        if (exp_we == 1) begin
            check("mem_wr_word", got_wr, ref_word(a >> 2));
            check("mem_wr_addr", got_waddr, {addr[31:2], 2'b00});
        end
    endtask

    int          rdy_idx [$];
    logic [31:0] b2b_data [$];

    initial begin
        checks = 0;
        errors = 0;
        rst_low = 1'b0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        lsu_bus.req_valid_in = 1'b0; lsu_bus.req_we_in = 1'b0;
        lsu_bus.req_size_in = LSU_SIZE_BYTE; lsu_bus.req_unsigned_in = 1'b0;
        lsu_bus.req_addr_in = '0; lsu_bus.req_wdata_in = '0;

        // Preload memory while held in reset.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_idx  = 4'(i);
            pl_data = (i == 1) ? 32'h11223344 : (i == 2) ? 32'h0000BEEF : $urandom;
            for (int j = 0; j < 4; j++) ref_bytes[4 * i + j] = 8'(pl_data >> (8 * j));
        end
        @(negedge clk);
        pl_en = 1'b0;

        check("rst_resp_valid", 32'(lsu_bus.resp_valid_out), 32'd0);
        check("rst_mem_we", 32'(lsu_bus.mem_we_out), 32'd0);
        check("rst_mem_addr", lsu_bus.mem_addr_out, 32'd0);
        check("rst_mem_wr", lsu_bus.mem_wr_out, 32'd0);
        check("rst_rdata", lsu_bus.resp_rdata_out, 32'd0);
        check("rst_err", 32'(lsu_bus.resp_err_out), 32'd0);
        rst_low = 1'b1;
        #1 check("ready_after_reset", 32'(lsu_bus.req_ready_out), 32'd1);

        // Directed cases.
        do_req(1, 2, 0, 32'h0, 32'h0000A5A5);
        check("word_store_mem0", tb_mem[0], 32'h0000A5A5);
        do_req(1, 0, 0, 32'h5, 32'h0000003C);
        check("byte_store_mem1", tb_mem[1], 32'h11223C44);
        do_req(1, 2, 0, 32'h4, 32'h11228044);
        do_req(0, 0, 0, 32'h5, 32'h0);   // expects 0xFFFFFF80
        do_req(0, 0, 1, 32'h5, 32'h0);   // expects 0x00000080
        do_req(0, 1, 0, 32'h6, 32'h0);   // expects 0x00001122
        do_req(0, 1, 0, 32'h7, 32'h0);   // misaligned half
        do_req(1, 2, 0, 32'h2, 32'hDEADBEEF); // misaligned word store
        check("err_store_mem0", tb_mem[0], 32'h0000A5A5);
        do_req(0, 3, 0, 32'h8, 32'h0);   // reserved size

        // Back-to-back word loads with valid held high.
        @(negedge clk);
        lsu_bus.req_valid_in = 1'b1; lsu_bus.req_we_in = 1'b0;
        lsu_bus.req_size_in = LSU_SIZE_WORD; lsu_bus.req_unsigned_in = 1'b0;
        lsu_bus.req_addr_in = 32'h8;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 5) lsu_bus.req_valid_in = 1'b0;
            if (lsu_bus.req_ready_out) rdy_idx.push_back(i);
            if (lsu_bus.resp_valid_out) b2b_data.push_back(lsu_bus.resp_rdata_out);
        end
        check("b2b_ready_count", rdy_idx.size(), 3);
        if (rdy_idx.size() >= 2) begin
            check("b2b_first_ready", rdy_idx[0], 0);
            check("b2b_second_ready", rdy_idx[1], 4);
        end
        check("b2b_resp_count", b2b_data.size(), 2);
        for (int i = 0; i < b2b_data.size(); i++) check("b2b_rdata", b2b_data[i], ref_word(2));

        // Reset during WR of a byte store.
        @(negedge clk);
        lsu_bus.req_valid_in = 1'b1; lsu_bus.req_we_in = 1'b1;
        lsu_bus.req_size_in = LSU_SIZE_BYTE; lsu_bus.req_addr_in = 32'h9;
        lsu_bus.req_wdata_in = 32'h77;
        @(posedge clk);
        #1 lsu_bus.req_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_we_in_wr", 32'(lsu_bus.mem_we_out), 32'd1);
        rst_low = 1'b0;
        #1 check("abort_we_dropped", 32'(lsu_bus.mem_we_out), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_low = 1'b1;
        #1;
        check("abort_ready", 32'(lsu_bus.req_ready_out), 32'd1);
        check("abort_resp_valid", 32'(lsu_bus.resp_valid_out), 32'd0);
        check("abort_mem_unchanged", tb_mem[2], ref_word(2));

        // Randomized requests.
        for (int n = 0; n < 60; n++) begin
            int unsigned sz, a;
            sz = $urandom_range(0, 3);
            a  = $urandom_range(0, 63);
            if ($urandom_range(0, 2) != 0 && sz < 3) a = a & ~((1 << sz) - 1);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), 32'(a), $urandom);
        end

        for (int i = 0; i < 16; i++) check("final_mem", tb_mem[i], ref_word(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
